// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: controller state encoding.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_bit_full_add.sv
// One-bit full-add cell built from two half adders plus an OR on the carries.
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module bit_full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0, c0, c1;

    half_add u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_add u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one shared full-add cell LSB first, one bit per cycle,
// between an operand valid/ready handshake and a result valid/ready handshake.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
    logic             fa_s, fa_c;

    bit_full_add u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB; written as a widened shift so WIDTH=1 needs no special slice.
    assign res_nxt = WIDTH'({fa_s, res_sh} >> 1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)     state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST)  state_nxt = ST_DONE;
            ST_DONE: if (out_ready)    state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= in_b;
                        carry <= in_cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    carry  <= fa_c;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        out_sum  <= res_nxt;
                        out_cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed scoreboard bench for serial_add_ctrl at WIDTH=4 and WIDTH=1.
module tb_serial_add_ctrl;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_cin, out_ready;
    logic [3:0] in_a, in_b;
    logic       in_ready, out_valid, out_cout, busy;
    logic [3:0] out_sum;

    logic       w1_in_valid, w1_in_a, w1_in_b, w1_in_cin, w1_out_ready;
    logic       w1_in_ready, w1_out_valid, w1_out_sum, w1_out_cout, w1_busy;

    res_t q4[$];
    res_t q1[$];
    int   ncmp  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .in_a(w1_in_a), .in_b(w1_in_b), .in_cin(w1_in_cin), .out_valid(w1_out_valid),
        .out_ready(w1_out_ready), .out_sum(w1_out_sum), .out_cout(w1_out_cout), .busy(w1_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one WIDTH=4 op, optionally poke in_valid mid-RUN, then hold out_ready low for hold cycles.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input int hold, input bit poke);
        logic [4:0] full;
        int         cyc;
        res_t       exp, snap;
        @(negedge clk);
        check("in_ready_before", in_ready, 1'b1);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
        full = 5'(a) + 5'(b) + 5'(cin);
        q4.push_back('{sum: full[3:0], cout: full[4]});
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            if (poke && cyc == 1) begin in_valid = 1'b1; in_a = 4'h3; in_b = 4'h3; in_cin = 1'b1; end
            if (poke && cyc == 2) in_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", cyc, 4);
        snap = '{sum: out_sum, cout: out_cout};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_sum", out_sum, snap.sum);
            check("hold_cout", out_cout, snap.cout);
        end
        check("q4_nonempty", q4.size() > 0, 1'b1);
        if (q4.size() > 0) begin
            exp = q4.pop_front();
            check("sum", out_sum, exp.sum);
            check("cout", out_cout, exp.cout);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_sum_held", out_sum, snap.sum);
    endtask

    task automatic run1(input logic a, input logic b, input logic cin);
        logic [1:0] full;
        int         cyc;
        res_t       exp;
        @(negedge clk);
        check("w1_in_ready", w1_in_ready, 1'b1);
        w1_in_valid = 1'b1; w1_in_a = a; w1_in_b = b; w1_in_cin = cin;
        full = 2'(a) + 2'(b) + 2'(cin);
        q1.push_back('{sum: {3'b000, full[0]}, cout: full[1]});
        @(negedge clk);
        w1_in_valid = 1'b0;
        cyc = 0;
        while (!w1_out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("w1_latency", cyc, 1);
        check("q1_nonempty", q1.size() > 0, 1'b1);
        if (q1.size() > 0) begin
            exp = q1.pop_front();
            check("w1_sum", w1_out_sum, exp.sum[0]);
            check("w1_cout", w1_out_cout, exp.cout);
        end
        w1_out_ready = 1'b1;
        @(negedge clk);
        w1_out_ready = 1'b0;
        check("w1_idle", w1_in_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        w1_in_valid = 1'b0; w1_in_a = 1'b0; w1_in_b = 1'b0; w1_in_cin = 1'b0; w1_out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", out_sum, 4'h0);
        check("rst_cout", out_cout, 1'b0);
        rst_n = 1'b1;

        run4(4'h1, 4'h1, 1'b0, 0, 1'b0);
        run4(4'h8, 4'h8, 1'b0, 0, 1'b0);
        run4(4'hF, 4'h0, 1'b1, 0, 1'b0);
        run4(4'h7, 4'h8, 1'b1, 3, 1'b0);
        run4(4'h6, 4'h9, 1'b0, 0, 1'b1);
        run4(4'h5, 4'hA, 1'b0, 0, 1'b0);

        // Abandon an op with reset at its second RUN cycle.
        @(negedge clk);
        in_valid = 1'b1; in_a = 4'h9; in_b = 4'h9; in_cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_sum", out_sum, 4'h0);
        check("abort_cout", out_cout, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 1'b0);
        end

        run4(4'h2, 4'h3, 1'b0, 0, 1'b0);

        run1(1'b1, 1'b1, 1'b0);
        run1(1'b0, 1'b0, 1'b1);
        run1(1'b1, 1'b0, 1'b1);
        run1(1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
